dec_hazard_scoreboard: RTL

- Decode-stage register scoreboard that sits directly upstream of the DEC/EXE pipeline register.
- Tracks in-flight register writes per architectural register and stalls decode on RAW hazards or counter overflow.
- Drives the DEC/EXE register: `issue` is its enable, and `bubble` selects NOP insertion (mem/regfile write enables forced 0).
- Releases reservations on writeback and on EXE-stage flush (branch mispredict).

---
 rtl/dec_hazard_scoreboard.sv | 111 +++++++++++
 1 files changed

// File: rtl/dec_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : dec_hazard_scoreboard
// Purpose  : Decode-stage register scoreboard. It counts in-flight writes per
//            register, stalls decode on RAW hazards or counter overflow, and
//            drives the enable and bubble controls of the DEC/EXE register.
// Options  : SCOREBOARD_WB_BYPASS_EN - source checks see same-cycle writeback
// Revision : 1.0 - initial release
// ============================================================================
module dec_hazard_scoreboard #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int NUM_REGS            = 16,
  parameter int CNT_WIDTH           = 2,
  parameter int STALL_CNT_WIDTH     = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dec_valid,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src1,
  input  logic                           dec_src1_used,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src2,
  input  logic                           dec_src2_used,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_dst,
  input  logic                           dec_wrt_en,
  input  logic                           wb_valid,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] wb_dst,
  input  logic                           flush,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] flush_dst,
  input  logic                           flush_wrt_en,
  output logic                           stall,
  output logic                           issue,
  output logic                           bubble,
  output logic [NUM_REGS-1:0]            busy_vec,
  output logic [STALL_CNT_WIDTH-1:0]     stall_count,
  output logic                           err
);

  localparam logic [CNT_WIDTH-1:0]       C_CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [STALL_CNT_WIDTH-1:0] C_STALL_MAX = {STALL_CNT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0]       r_pending [NUM_REGS];
  logic [CNT_WIDTH-1:0]       w_next    [NUM_REGS];
  logic [STALL_CNT_WIDTH-1:0] r_stall_count;
  logic                       r_err;

  logic [NUM_REGS-1:0] w_wb_hit;
  logic [NUM_REGS-1:0] w_flush_hit;
  logic [NUM_REGS-1:0] w_src_busy;
  logic [NUM_REGS-1:0] w_full;
  logic [NUM_REGS-1:0] w_underflow;
  logic                w_hazard;
  logic                w_issue;
  logic                w_stall;

  generate
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      logic                 w_inc;
      logic [CNT_WIDTH:0]   w_sum;
      logic [CNT_WIDTH:0]   w_dec;

      assign w_wb_hit[r]    = wb_valid & (wb_dst == REG_INDEX_BIT_WIDTH'(r));
      assign w_flush_hit[r] = flush & flush_wrt_en & (flush_dst == REG_INDEX_BIT_WIDTH'(r));
      assign busy_vec[r]    = (r_pending[r] != '0);
      assign w_full[r]      = (r_pending[r] == C_CNT_MAX);

`ifdef SCOREBOARD_WB_BYPASS_EN
      // Write-through regfile: a last pending write retiring now is already visible.
      assign w_src_busy[r]  = busy_vec[r] & ~(w_wb_hit[r] & (r_pending[r] == CNT_WIDTH'(1)));
`else
      assign w_src_busy[r]  = busy_vec[r];
`endif

      // One extra bit so that pending + inc - dec can be tested for underflow.
      assign w_inc          = w_issue & dec_wrt_en & (dec_dst == REG_INDEX_BIT_WIDTH'(r));
      assign w_sum          = {1'b0, r_pending[r]} + (CNT_WIDTH+1)'(w_inc);
      assign w_dec          = (CNT_WIDTH+1)'(w_wb_hit[r]) + (CNT_WIDTH+1)'(w_flush_hit[r]);
      assign w_underflow[r] = (w_sum < w_dec);
      assign w_next[r]      = w_underflow[r] ? '0 : CNT_WIDTH'(w_sum - w_dec);
    end : g_reg
  endgenerate

  assign w_hazard = dec_valid & ((dec_src1_used & w_src_busy[dec_src1]) |
                                 (dec_src2_used & w_src_busy[dec_src2]) |
                                 (dec_wrt_en    & w_full[dec_dst]));

  // Flush overrides everything: the decode instruction is squashed, not held.
  assign w_stall = w_hazard & ~flush;
  assign w_issue = dec_valid & ~w_hazard & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_pending[i] <= '0;
      r_stall_count <= '0;
      r_err         <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) r_pending[i] <= w_next[i];
      if (w_stall && (r_stall_count != C_STALL_MAX))
        r_stall_count <= r_stall_count + STALL_CNT_WIDTH'(1);
      if (|w_underflow)
        r_err <= 1'b1;
    end
  end

  assign stall       = w_stall;
  assign issue       = w_issue;
  assign bubble      = ~w_issue;
  assign stall_count = r_stall_count;
  assign err         = r_err;

endmodule
`default_nettype wire
